// File: rtl/l2_mem_responder.sv
// Fixed-latency single-outstanding L2 line memory responder.
// Define L2_RESP_WRITE_ECHO_EN to return the written line on write responses.
module l2_mem_responder #(
    parameter int ADDR_W  = 11,
    parameter int DATA_W  = 256,
    parameter int LATENCY = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              L2_req,
    input  logic              L2_we,
    input  logic [ADDR_W-1:0] L2_addr,
    input  logic [DATA_W-1:0] L2_wdata,
    output logic              L2_ready,
    output logic [DATA_W-1:0] L2_rdata,
    output logic              L2_busy,
    output logic              L2_drop
);

`ifdef L2_RESP_WRITE_ECHO_EN
    localparam bit ECHO_EN = 1'b1;
`else
    localparam bit ECHO_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [3:0]        r_cnt;
    logic              r_we;
    logic [DATA_W-1:0] r_line;
    logic [DATA_W-1:0] r_rdata;
    logic              r_drop;
    logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];

    logic              w_accept;
    logic              w_enter_resp;
    logic              w_resp_we;
    logic              w_rdata_load;
    logic [DATA_W-1:0] w_cap_line;
    logic [DATA_W-1:0] w_resp_line;

    assign w_accept   = (r_state == IDLE) && L2_req;
    assign w_cap_line = L2_we ? L2_wdata : r_mem[L2_addr];

    // With LATENCY=1 the capture edge is also the RESP entry edge, so the
    // response line comes straight from the request inputs in that case.
    assign w_enter_resp = (w_state_next == RESP) && (r_state != RESP);
    assign w_resp_we    = (r_state == IDLE) ? L2_we : r_we;
    assign w_resp_line  = (r_state == IDLE) ? w_cap_line : r_line;
    assign w_rdata_load = w_enter_resp && (ECHO_EN || !w_resp_we);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: if (L2_req) w_state_next = (LATENCY == 1) ? RESP : BUSY;
            BUSY: if (r_cnt == 4'd1) w_state_next = RESP;
            RESP: w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        L2_ready = (r_state == RESP);
        L2_busy  = (r_state != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_line  <= '0;
            r_rdata <= '0;
            r_drop  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_cnt  <= 4'(LATENCY - 1);
                r_we   <= L2_we;
                r_line <= w_cap_line;
            end else if (r_state == BUSY) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (L2_req && (r_state != IDLE)) begin
                r_drop <= 1'b1;
            end
            if (w_rdata_load) begin
                r_rdata <= w_resp_line;
            end
        end
    end

    // Line storage has no reset so committed writes survive rst.
    always_ff @(posedge clk) begin
        if (w_accept && L2_we) begin
            r_mem[L2_addr] <= L2_wdata;
        end
    end

    assign L2_rdata = r_rdata;
    assign L2_drop  = r_drop;

endmodule

// File: tb/tb_l2_mem_responder.sv
// Bench for l2_mem_responder: directed vector table, reset and LATENCY=1 sequences,
// then randomized traffic against a cycle-number based reference model.
module tb_l2_mem_responder;

    localparam int AW  = 11;
    localparam int DW  = 256;
    localparam int LAT = 4;

`ifdef L2_RESP_WRITE_ECHO_EN
    localparam bit ECHO = 1'b1;
`else
    localparam bit ECHO = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req, we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          ready, busy, drop;
    logic [DW-1:0] rdata;

    logic          req1, we1;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata1;
    logic          ready1, busy1, drop1;
    logic [DW-1:0] rdata1;

    l2_mem_responder #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(LAT)) u_dut (
        .clk(clk), .rst(rst), .L2_req(req), .L2_we(we), .L2_addr(addr),
        .L2_wdata(wdata), .L2_ready(ready), .L2_rdata(rdata),
        .L2_busy(busy), .L2_drop(drop)
    );

    l2_mem_responder #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst), .L2_req(req1), .L2_we(we1), .L2_addr(addr1),
        .L2_wdata(wdata1), .L2_ready(ready1), .L2_rdata(rdata1),
        .L2_busy(busy1), .L2_drop(drop1)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        bit            req;
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        bit            e_ready;
        bit            e_busy;
        bit            e_drop;
        logic [DW-1:0] e_rd;
    } vec_t;

    vec_t          vecs[$];
    logic [DW-1:0] f_rd;
    bit            f_drop;

    task automatic add_row(input bit rq, input bit w, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input bit er, input bit eb);
        vec_t v;
        v.req = rq; v.we = w; v.addr = a; v.wdata = d;
        v.e_ready = er; v.e_busy = eb; v.e_drop = f_drop; v.e_rd = f_rd;
        vecs.push_back(v);
    endtask

    // One accepted transaction: request row, LAT-1 busy rows, response row.
    task automatic add_txn(input bit w, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [DW-1:0] rd_val);
        add_row(1'b1, w, a, d, 1'b0, 1'b0);
        for (int i = 0; i < LAT - 1; i++) add_row(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
        f_rd = w ? (ECHO ? d : f_rd) : rd_val;
        add_row(1'b0, 1'b0, '0, '0, 1'b1, 1'b1);
    endtask

    logic [DW-1:0] mem_m [logic [AW-1:0]];
    logic [AW-1:0] pool [8];

    initial begin
        logic [DW-1:0] vA, vB, vC, vD, vE, v3C, exp_rd, pend, d;
        logic [AW-1:0] a;
        bit            pend_upd, exp_drop, mbusy, e_ready, r, w;
        int            cyc, acc_c, resp_c, got;

        vA = {32{8'hA5}}; vB = {32{8'h5A}}; vC = {32{8'hC3}};
        vD = {32{8'h96}}; vE = {32{8'h1E}}; v3C = {32{8'h3C}};

        req = 0; we = 0; addr = '0; wdata = '0;
        req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;

        repeat (3) @(negedge clk);
        check("rst ready", ready, 0);
        check("rst busy", busy, 0);
        check("rst drop", drop, 0);
        check("rst rdata", rdata, 0);
        check("rst1 ready", ready1, 0);
        check("rst1 rdata", rdata1, 0);
        rst = 0;
        repeat (2) @(negedge clk);

        f_rd = '0; f_drop = 0;
        add_txn(1'b1, 11'h005, vA, '0);
        add_txn(1'b0, 11'h005, '0, vA);
        add_txn(1'b1, 11'h7FF, vB, '0);
        add_txn(1'b1, 11'h123, vC, '0);
        add_row(1'b1, 1'b0, 11'h7FF, '0, 1'b0, 1'b0);
        add_row(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
        add_row(1'b1, 1'b1, 11'h123, vD, 1'b0, 1'b1);
        f_drop = 1;
        add_row(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
        f_rd = vB;
        add_row(1'b0, 1'b0, '0, '0, 1'b1, 1'b1);
        add_txn(1'b1, 11'h010, vE, '0);
        add_txn(1'b0, 11'h010, '0, vE);
        add_txn(1'b0, 11'h123, '0, vC);
        add_row(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);

        foreach (vecs[i]) begin
            @(negedge clk);
            check($sformatf("vec%0d ready", i), ready, vecs[i].e_ready);
            check($sformatf("vec%0d busy", i), busy, vecs[i].e_busy);
            check($sformatf("vec%0d drop", i), drop, vecs[i].e_drop);
            check($sformatf("vec%0d rdata", i), rdata, vecs[i].e_rd);
            req = vecs[i].req; we = vecs[i].we; addr = vecs[i].addr; wdata = vecs[i].wdata;
        end

        // Reset one cycle after a read request discards that response.
        @(negedge clk);
        req = 1; we = 0; addr = 11'h7FF;
        @(negedge clk);
        check("pre-rst busy", busy, 1);
        req = 0; rst = 1;
        #1;
        check("async rst ready", ready, 0);
        check("async rst busy", busy, 0);
        check("async rst drop", drop, 0);
        check("async rst rdata", rdata, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check($sformatf("post-rst no ready %0d", k), ready, 0);
        end
        req = 1; we = 0; addr = 11'h005;
        got = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            req = 0;
            if (ready) begin
                got = k;
                break;
            end
        end
        check("post-rst latency", got, LAT);
        check("post-rst retained rdata", rdata, vA);

        // LATENCY=1 instance.
        @(negedge clk);
        req1 = 1; we1 = 1; addr1 = 11'h001; wdata1 = v3C;
        @(negedge clk);
        check("lat1 wr ready", ready1, 1);
        check("lat1 wr busy", busy1, 1);
        check("lat1 wr rdata", rdata1, ECHO ? v3C : '0);
        req1 = 1; we1 = 0;
        @(negedge clk);
        check("lat1 idle ready", ready1, 0);
        check("lat1 idle busy", busy1, 0);
        check("lat1 drop", drop1, 1);
        req1 = 1; we1 = 0;
        @(negedge clk);
        check("lat1 rd ready", ready1, 1);
        check("lat1 rd rdata", rdata1, v3C);
        req1 = 0;
        @(negedge clk);
        check("lat1 rd ready low", ready1, 0);
        check("lat1 rd held", rdata1, v3C);

        // Randomized traffic vs. reference model.
        mem_m[11'h005] = vA; mem_m[11'h7FF] = vB; mem_m[11'h123] = vC; mem_m[11'h010] = vE;
        pool = '{11'h005, 11'h7FF, 11'h123, 11'h010, 11'h000, 11'h2AA, 11'h555, 11'h7FE};
        exp_rd = vA; exp_drop = 0; pend = '0; pend_upd = 0;
        cyc = 0; acc_c = -100; resp_c = -100;
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            cyc++;
            mbusy   = (cyc > acc_c) && (cyc <= resp_c);
            e_ready = (cyc == resp_c);
            if (e_ready && pend_upd) exp_rd = pend;
            check($sformatf("rnd%0d ready", n), ready, e_ready);
            check($sformatf("rnd%0d busy", n), busy, mbusy);
            check($sformatf("rnd%0d drop", n), drop, exp_drop);
            check($sformatf("rnd%0d rdata", n), rdata, exp_rd);
            r = ($urandom_range(0, 99) < 35);
            w = 1'($urandom_range(0, 1));
            a = pool[$urandom_range(0, 7)];
            for (int j = 0; j < 8; j++) d[j*32 +: 32] = $urandom();
            if (!w && !mem_m.exists(a)) w = 1;
            req = r; we = w; addr = a; wdata = d;
            if (r) begin
                if (mbusy) begin
                    exp_drop = 1;
                end else begin
                    acc_c  = cyc;
                    resp_c = cyc + LAT;
                    if (w) begin
                        mem_m[a] = d;
                        pend = d;
                        pend_upd = ECHO;
                    end else begin
                        pend = mem_m[a];
                        pend_upd = 1;
                    end
                end
            end
        end
        req = 0;
        repeat (LAT + 2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
